sum_pipe: RTL and testbench

Parametrised pipelined adder/subtractor, the successor to the combinational 64-bit sum block. It splits the WIDTH-bit operation into STAGES = WIDTH/STAGE_W slices, adding one slice per stage with a registered carry between stages. A valid/ready handshake allows back-to-back operation with backpressure. It also produces signed-overflow and zero flags, and is used wherever wide adds must close timing at full clock rate.

---
 rtl/sum_pipe.sv | 125 ++++++++++++
 tb/tb_sum_pipe.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sum_pipe.sv
// sum_pipe: pipelined WIDTH-bit adder/subtractor. Stage k adds slice k, and a
// registered carry links one stage to the next. A valid/ready handshake stalls
// the whole pipeline as a unit.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   in_valid / in_ready  input handshake (in_ready = pipeline may advance)
//   a, b, cin, sub       operands; sub=1 computes a - b - cin
//   out_valid/out_ready  output handshake
//   s, cout, ovf, zero   result, carry out (sub: 1 = no borrow),
//                        signed overflow, s == 0
//
// The latency is STAGES cycles. The bubbles are kept in the pipeline and are not collapsed.
module sum_pipe #(
    parameter int WIDTH   = 64,
    parameter int STAGE_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int SW_SAFE = (STAGE_W < 1) ? 1 : STAGE_W;
    localparam int STAGES  = (WIDTH / SW_SAFE < 1) ? 1 : WIDTH / SW_SAFE;
    localparam int LAST    = STAGES - 1;

    generate
        if (STAGE_W < 1 || (WIDTH % SW_SAFE) != 0 || WIDTH < SW_SAFE) begin : g_param_check
            $error("sum_pipe: WIDTH must be a non-zero multiple of STAGE_W (STAGE_W >= 1)");
        end
    endgenerate

    logic en;

    // Stage registers. a_q/b_q carry the full operands. The slices that are not yet
    // added are still in the skew and are read later. The MSBs are needed for ovf.
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] cy_q;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic              ovf_q;
    logic              zero_q;

    // Values that each stage loads on en.
    logic [STAGES-1:0] vld_src;
    logic [STAGES-1:0] cy_src;
    logic [WIDTH-1:0]  a_src [STAGES];
    logic [WIDTH-1:0]  b_src [STAGES];
    logic [WIDTH-1:0]  s_src [STAGES];
    logic [WIDTH-1:0]  s_nxt [STAGES];
    logic [STAGE_W:0]  slice [STAGES];
    logic [STAGES-1:0] cy_nxt;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_comb begin
        // The operands are conditioned once, at the input. The later stages see only an add.
        vld_src[0] = in_valid;
        cy_src[0]  = sub ? ~cin : cin;
        a_src[0]   = a;
        b_src[0]   = sub ? ~b : b;
        s_src[0]   = '0;
        for (int k = 1; k < STAGES; k++) begin
            vld_src[k] = vld_q[k-1];
            cy_src[k]  = cy_q[k-1];
            a_src[k]   = a_q[k-1];
            b_src[k]   = b_q[k-1];
            s_src[k]   = s_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            slice[k] = {1'b0, a_src[k][k*STAGE_W +: STAGE_W]}
                     + {1'b0, b_src[k][k*STAGE_W +: STAGE_W]}
                     + {{STAGE_W{1'b0}}, cy_src[k]};
            s_nxt[k] = s_src[k];
            s_nxt[k][k*STAGE_W +: STAGE_W] = slice[k][STAGE_W-1:0];
            cy_nxt[k] = slice[k][STAGE_W];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q  <= '0;
            cy_q   <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (en) begin
            vld_q <= vld_src;
            cy_q  <= cy_nxt;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_src[k];
                b_q[k] <= b_src[k];
                s_q[k] <= s_nxt[k];
            end
            // The flags are computed from the complete sum that the last stage produces.
            // They are registered with s.
            ovf_q  <= (a_src[LAST][WIDTH-1] == b_src[LAST][WIDTH-1]) &&
                      (s_nxt[LAST][WIDTH-1] != a_src[LAST][WIDTH-1]);
            zero_q <= (s_nxt[LAST] == '0);
        end
    end

    assign out_valid = vld_q[LAST];
    assign s         = s_q[LAST];
    assign cout      = cy_q[LAST];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_sum_pipe.sv
// tb_sum_pipe: directed testbench for sum_pipe (WIDTH=64, STAGE_W=16).
module tb_sum_pipe;
    localparam int WIDTH   = 64;
    localparam int STAGE_W = 16;
    localparam logic [WIDTH-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;

    int n_checks = 0;
    int n_fail   = 0;

    sum_pipe #(.WIDTH(WIDTH), .STAGE_W(STAGE_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    endtask

    // One operation is presented at the negedge. It is accepted at the next posedge.
    // The task assumes that in_ready is high.
    task automatic send_one(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                            input logic vc, input logic vs);
        @(negedge clk);
        in_valid = 1'b1; a = va; b = vb; cin = vc; sub = vs;
        @(posedge clk); #1;
        drive_idle();
    endtask

    // The task is called 1 time unit after the accept edge. It returns the number of extra edges to out_valid.
    task automatic wait_out(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; out_ready = 1'b1; drive_idle();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (s !== '0) begin n_fail++; $display("FAIL reset_s: got %h expected 0", s); end
        n_checks++; if ({cout, ovf, zero} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {cout, ovf, zero}); end
        @(negedge clk); reset = 1'b0; #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_carry_ripple();
        int cyc;
        send_one(ONES, 64'h1, 1'b0, 1'b0);
        wait_out(cyc);
        n_checks++; if (out_valid !== 1'b1 || cyc + 1 != 4) begin n_fail++; $display("FAIL ripple_latency: got valid=%b latency=%0d expected valid=1 latency=4", out_valid, cyc + 1); end
        n_checks++; if (s !== '0) begin n_fail++; $display("FAIL ripple_s: got %h expected 0", s); end
        n_checks++; if ({cout, zero, ovf} !== 3'b110) begin n_fail++; $display("FAIL ripple_flags: got cout/zero/ovf=%b expected 110", {cout, zero, ovf}); end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int cyc;
        @(negedge clk);
        in_valid = 1'b1; a = 64'hAAAA_AAAA_AAAA_AAAA; b = 64'h5555_5555_5555_5555; cin = 1'b0; sub = 1'b0;
        @(posedge clk); #1;
        cin = 1'b1;
        @(posedge clk); #1;
        drive_idle();
        wait_out(cyc);
        n_checks++; if (out_valid !== 1'b1 || s !== ONES) begin n_fail++; $display("FAIL b2b_first_s: got valid=%b s=%h expected valid=1 s=%h", out_valid, s, ONES); end
        n_checks++; if ({cout, zero, ovf} !== 3'b000) begin n_fail++; $display("FAIL b2b_first_flags: got %b expected 000", {cout, zero, ovf}); end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b1 || s !== '0) begin n_fail++; $display("FAIL b2b_second_s: got valid=%b s=%h expected valid=1 s=0", out_valid, s); end
        n_checks++; if ({cout, zero, ovf} !== 3'b110) begin n_fail++; $display("FAIL b2b_second_flags: got %b expected 110", {cout, zero, ovf}); end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_sub();
        int cyc;
        send_one(64'd5, 64'd7, 1'b0, 1'b1);
        wait_out(cyc);
        n_checks++; if (out_valid !== 1'b1 || s !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("FAIL sub_neg_s: got valid=%b s=%h expected fffffffffffffffe", out_valid, s); end
        n_checks++; if ({cout, ovf, zero} !== 3'b000) begin n_fail++; $display("FAIL sub_neg_flags: got cout/ovf/zero=%b expected 000", {cout, ovf, zero}); end
        repeat (2) @(posedge clk);
        send_one(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1);
        wait_out(cyc);
        n_checks++; if (out_valid !== 1'b1 || s !== 64'h7FFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL sub_ovf_s: got valid=%b s=%h expected 7fffffffffffffff", out_valid, s); end
        n_checks++; if ({cout, ovf, zero} !== 3'b110) begin n_fail++; $display("FAIL sub_ovf_flags: got cout/ovf/zero=%b expected 110", {cout, ovf, zero}); end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_add_ovf();
        int cyc;
        send_one(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        wait_out(cyc);
        n_checks++; if (out_valid !== 1'b1 || s !== 64'h8000_0000_0000_0000) begin n_fail++; $display("FAIL add_ovf_s: got valid=%b s=%h expected 8000000000000000", out_valid, s); end
        n_checks++; if ({cout, ovf, zero} !== 3'b010) begin n_fail++; $display("FAIL add_ovf_flags: got cout/ovf/zero=%b expected 010", {cout, ovf, zero}); end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] op_a [6];
        logic [WIDTH-1:0] op_b [6];
        logic             op_c [6];
        logic             op_s [6];
        logic [WIDTH-1:0] exp_s [6];
        logic             exp_c [6];
        logic             exp_v [6];
        logic             exp_z [6];
        logic [WIDTH:0]   full;
        int tx = 0, rx = 0, cyc = 0;
        for (int i = 0; i < 6; i++) begin
            op_a[i] = {$urandom(), $urandom()};
            op_b[i] = {$urandom(), $urandom()};
            op_c[i] = 1'($urandom_range(0, 1));
            op_s[i] = 1'(i % 2);
            if (op_s[i]) begin
                full     = {1'b0, op_a[i]} - {1'b0, op_b[i]} - {{WIDTH{1'b0}}, op_c[i]};
                exp_c[i] = ~full[WIDTH];
                exp_v[i] = (op_a[i][WIDTH-1] != op_b[i][WIDTH-1]) && (full[WIDTH-1] != op_a[i][WIDTH-1]);
            end else begin
                full     = {1'b0, op_a[i]} + {1'b0, op_b[i]} + {{WIDTH{1'b0}}, op_c[i]};
                exp_c[i] = full[WIDTH];
                exp_v[i] = (op_a[i][WIDTH-1] == op_b[i][WIDTH-1]) && (full[WIDTH-1] != op_a[i][WIDTH-1]);
            end
            exp_s[i] = full[WIDTH-1:0];
            exp_z[i] = (full[WIDTH-1:0] == '0);
        end
        while (rx < 6 && cyc < 200) begin
            @(negedge clk);
            out_ready = (cyc >= 12);
            if (tx < 6) begin
                in_valid = 1'b1; a = op_a[tx]; b = op_b[tx]; cin = op_c[tx]; sub = op_s[tx];
            end else begin
                drive_idle();
            end
            #1;
            if (cyc == 11) begin
                n_checks++; if (tx != 4) begin n_fail++; $display("FAIL bp_accepted_while_stalled: got %0d expected 4", tx); end
            end
            if (out_valid && !out_ready) begin
                n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
                n_checks++; if (s !== exp_s[rx]) begin n_fail++; $display("FAIL bp_hold: got %h expected %h", s, exp_s[rx]); end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (s !== exp_s[rx] || cout !== exp_c[rx] || ovf !== exp_v[rx] || zero !== exp_z[rx]) begin
                    n_fail++;
                    $display("FAIL bp_result%0d: got s=%h c=%b v=%b z=%b expected s=%h c=%b v=%b z=%b",
                             rx, s, cout, ovf, zero, exp_s[rx], exp_c[rx], exp_v[rx], exp_z[rx]);
                end
                rx++;
            end
            if (in_valid && in_ready) tx++;
            cyc++;
        end
        n_checks++; if (rx != 6) begin n_fail++; $display("FAIL bp_count: got %0d results expected 6", rx); end
        drive_idle();
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_duplicate: got out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit stale = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b1; a = 64'd1; b = 64'd1; cin = 1'b0; sub = 1'b0;
        @(posedge clk); #1; a = 64'd2; b = 64'd2;
        @(posedge clk); #1; a = 64'd3; b = 64'd3;
        @(posedge clk); #1; drive_idle();
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b1 || s !== 64'd2) begin n_fail++; $display("FAIL rstmid_pre: got valid=%b s=%h expected valid=1 s=2", out_valid, s); end
        reset = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
        n_checks++; if (s !== '0 || {cout, ovf, zero} !== 3'b000) begin n_fail++; $display("FAIL rstmid_outputs: got s=%h flags=%b expected 0/000", s, {cout, ovf, zero}); end
        @(posedge clk);
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) stale = 1'b1;
        end
        n_checks++; if (stale) begin n_fail++; $display("FAIL rstmid_stale: got out_valid=1 after reset expected 0"); end
        send_one(64'd1, 64'd2, 1'b0, 1'b0);
        wait_out(cyc);
        n_checks++; if (out_valid !== 1'b1 || cyc + 1 != 4) begin n_fail++; $display("FAIL rstmid_latency: got valid=%b latency=%0d expected valid=1 latency=4", out_valid, cyc + 1); end
        n_checks++; if (s !== 64'd3) begin n_fail++; $display("FAIL rstmid_s: got %h expected 3", s); end
    endtask

    initial begin
        test_reset();
        test_carry_ripple();
        test_back_to_back();
        test_sub();
        test_add_ovf();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
